// File: rtl/freelist_bank_pkg.sv
// Shared constants, types and helpers for the rename free-list storage bank.
// FREELIST_WB_REG_EN (optional) adds a register stage on the retire-free path.
package freelist_bank_pkg;

    localparam int unsigned PR_W      = 7;
    localparam int unsigned PTR_W     = 7;
    localparam int unsigned FL_DEPTH  = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned IDX_W     = PTR_W - 1;

    typedef logic [PR_W-1:0]  pr_tag_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
    typedef logic [IDX_W-1:0] fl_idx_t;
    typedef logic [1:0]       wb_cnt_t;

    // Wrap bit set, index 0: the array starts full of free tags.
    localparam fl_ptr_t FL_RST_PTR = 7'b1000000;

    typedef struct packed {
        logic    valid;
        logic    wen;
        pr_tag_t old_pr;
    } retire_slot_t;

    typedef retire_slot_t [1:0] retire_free_t;

    function automatic fl_idx_t fl_idx(input fl_ptr_t p);
        return p[IDX_W-1:0];
    endfunction

    function automatic pr_tag_t reset_tag(input int unsigned entry);
        return pr_tag_t'(ARCH_REGS + entry);
    endfunction

endpackage

// File: rtl/freelist_bank_if.sv
// Retire-free / allocation-read bundle between the free-list bank and its neighbours.
// The master side drives retire frees and the allocation pointer; the bank is the slave.
interface freelist_bank_if;
    import freelist_bank_pkg::*;

    logic [1:0] retire_valid;
    logic [1:0] retire_wen;
    pr_tag_t    retire_old_pr0;
    pr_tag_t    retire_old_pr1;
    fl_ptr_t    rd_ptr;
    pr_tag_t    alloc_pr0;
    pr_tag_t    alloc_pr1;
    wb_cnt_t    PR_num_wrback;

    modport master (
        output retire_valid,
        output retire_wen,
        output retire_old_pr0,
        output retire_old_pr1,
        output rd_ptr,
        input  alloc_pr0,
        input  alloc_pr1,
        input  PR_num_wrback
    );

    modport slave (
        input  retire_valid,
        input  retire_wen,
        input  retire_old_pr0,
        input  retire_old_pr1,
        input  rd_ptr,
        output alloc_pr0,
        output alloc_pr1,
        output PR_num_wrback
    );

endinterface

// File: rtl/freelist_wr_compact.sv
// Packs up to two retire frees into consecutive write slots with a 0..2 count.
// Purely combinational.
module freelist_wr_compact
    import freelist_bank_pkg::*;
(
    input  retire_free_t slots,
    output wb_cnt_t      count,
    output pr_tag_t      wdata0,
    output pr_tag_t      wdata1
);

    logic free0;
    logic free1;

    always_comb begin
        free0  = slots[0].valid & slots[0].wen;
        free1  = slots[1].valid & slots[1].wen;
        count  = {1'b0, free0} + {1'b0, free1};
        // A lone slot-1 free moves down to the first write position.
        wdata0 = free0 ? slots[0].old_pr : slots[1].old_pr;
        wdata1 = slots[1].old_pr;
    end

endmodule

// File: rtl/freelist_bank.sv
// Free-list storage bank: 64-entry circular array of free physical tags.
// Build option FREELIST_WB_REG_EN registers retire frees before the array write.
module freelist_bank
    import freelist_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    freelist_bank_if.slave       bus
);

    retire_free_t ret_in;
    retire_free_t wb_src;
    wb_cnt_t      wb_count;
    pr_tag_t      wb_data0;
    pr_tag_t      wb_data1;

    fl_ptr_t      wr_ptr_q;
    fl_ptr_t      wr_ptr_d;
    fl_ptr_t      wr_ptr_p1;
    fl_ptr_t      rd_ptr_p1;

    pr_tag_t      mem_q [FL_DEPTH];
    pr_tag_t      mem_d [FL_DEPTH];

    always_comb begin
        ret_in[0].valid  = bus.retire_valid[0];
        ret_in[0].wen    = bus.retire_wen[0];
        ret_in[0].old_pr = bus.retire_old_pr0;
        ret_in[1].valid  = bus.retire_valid[1];
        ret_in[1].wen    = bus.retire_wen[1];
        ret_in[1].old_pr = bus.retire_old_pr1;
    end

`ifdef FREELIST_WB_REG_EN
    retire_free_t ret_q;
    retire_free_t ret_d;

    always_comb begin
        ret_d  = ret_in;
        wb_src = ret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q <= '0;
        end else begin
            ret_q <= ret_d;
        end
    end
`else
    always_comb begin
        wb_src = ret_in;
    end
`endif

    freelist_wr_compact u_wr_compact (
        .slots  (wb_src),
        .count  (wb_count),
        .wdata0 (wb_data0),
        .wdata1 (wb_data1)
    );

    always_comb begin
        wr_ptr_p1 = wr_ptr_q + fl_ptr_t'(1);
        wr_ptr_d  = wr_ptr_q + fl_ptr_t'(wb_count);
        mem_d     = mem_q;
        if (wb_count != 2'd0) begin
            mem_d[fl_idx(wr_ptr_q)] = wb_data0;
        end
        if (wb_count == 2'd2) begin
            mem_d[fl_idx(wr_ptr_p1)] = wb_data1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= FL_RST_PTR;
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= reset_tag(i);
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        rd_ptr_p1         = bus.rd_ptr + fl_ptr_t'(1);
        bus.alloc_pr0     = mem_q[fl_idx(bus.rd_ptr)];
        bus.alloc_pr1     = mem_q[fl_idx(rd_ptr_p1)];
        // Count is forced to zero while reset holds so the manager never advances.
        bus.PR_num_wrback = rst_n ? wb_count : '0;
    end

endmodule

// File: tb/tb_freelist_bank.sv
// Directed self-checking bench for freelist_bank (default build and FREELIST_WB_REG_EN).
module tb_freelist_bank;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    logic [6:0] model_wr;

    freelist_bank_if bus ();

    freelist_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic clear_retire();
        bus.retire_valid   = 2'b00;
        bus.retire_wen     = 2'b00;
        bus.retire_old_pr0 = '0;
        bus.retire_old_pr1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_retire();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_wr = 7'b1000000;
    endtask

    // Drives one retire cycle, checks the reported count, returns 1 time unit after the array write edge.
    task automatic retire(input logic [1:0] v, input logic [1:0] w, input logic [6:0] p0,
                          input logic [6:0] p1, input logic [1:0] exp_n, input string name);
        logic [6:0] room;
        bus.retire_valid   = v;
        bus.retire_wen     = w;
        bus.retire_old_pr0 = p0;
        bus.retire_old_pr1 = p1;
`ifdef FREELIST_WB_REG_EN
        @(posedge clk);
        #1;
        clear_retire();
`endif
        @(negedge clk);
        tests++;
        if (bus.PR_num_wrback !== exp_n) begin
            failed++;
            $display("FAIL %s: PR_num_wrback=%0d expected %0d", name, bus.PR_num_wrback, exp_n);
        end
        @(posedge clk);
        #1;
        clear_retire();
        model_wr = model_wr + 7'(exp_n);
        room = model_wr - bus.rd_ptr;
        assert (room <= 7'd64) else $error("room exceeded: wr=%0d rd=%0d", model_wr, bus.rd_ptr);
    endtask

    task automatic test_reset();
        logic [6:0] rp  [3] = '{7'd0, 7'd62, 7'd63};
        logic [6:0] e0  [3] = '{7'd32, 7'd94, 7'd95};
        logic [6:0] e1  [3] = '{7'd33, 7'd95, 7'd32};
        rst_n = 1'b0;
        clear_retire();
        bus.rd_ptr = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.PR_num_wrback !== 2'd0) begin
            failed++;
            $display("FAIL reset_wrback: got %0d expected 0", bus.PR_num_wrback);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_wr = 7'b1000000;
        for (int i = 0; i < 3; i++) begin
            bus.rd_ptr = rp[i];
            #1;
            tests++;
            if (bus.alloc_pr0 !== e0[i] || bus.alloc_pr1 !== e1[i]) begin
                failed++;
                $display("FAIL reset_read rd_ptr=%0d: got %0d,%0d expected %0d,%0d",
                         rp[i], bus.alloc_pr0, bus.alloc_pr1, e0[i], e1[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_slot1();
        bus.rd_ptr = 7'd64;
        retire(2'b11, 2'b10, 7'd99, 7'd5, 2'd1, "single_slot1");
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd5 || bus.alloc_pr1 !== 7'd33) begin
            failed++;
            $display("FAIL single_slot1_read: got %0d,%0d expected 5,33", bus.alloc_pr0, bus.alloc_pr1);
        end
    endtask

    task automatic test_no_free();
        retire(2'b11, 2'b00, 7'd70, 7'd71, 2'd0, "no_free");
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd5 || bus.alloc_pr1 !== 7'd33) begin
            failed++;
            $display("FAIL no_free_array: got %0d,%0d expected 5,33", bus.alloc_pr0, bus.alloc_pr1);
        end
        // Pointer must still be at entry 1.
        retire(2'b01, 2'b01, 7'd11, 7'd0, 2'd1, "slot0_only");
        retire(2'b11, 2'b01, 7'd12, 7'd99, 2'd1, "slot0_wen_only");
        bus.rd_ptr = 7'd65;
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd11 || bus.alloc_pr1 !== 7'd12) begin
            failed++;
            $display("FAIL no_free_ptr: got %0d,%0d expected 11,12", bus.alloc_pr0, bus.alloc_pr1);
        end
    endtask

    task automatic test_dual_wrap();
        do_reset();
        bus.rd_ptr = 7'd64;
        for (int k = 0; k < 31; k++) begin
            retire(2'b11, 2'b11, 7'(20 + 2*k), 7'(21 + 2*k), 2'd2, "fill_dual");
        end
        retire(2'b01, 2'b01, 7'd82, 7'd0, 2'd1, "fill_single");
        bus.rd_ptr = 7'd74;
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd30 || bus.alloc_pr1 !== 7'd31) begin
            failed++;
            $display("FAIL fill_read: got %0d,%0d expected 30,31", bus.alloc_pr0, bus.alloc_pr1);
        end
        bus.rd_ptr = 7'd126;
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd82 || bus.alloc_pr1 !== 7'd95) begin
            failed++;
            $display("FAIL fill_edge: got %0d,%0d expected 82,95", bus.alloc_pr0, bus.alloc_pr1);
        end
        bus.rd_ptr = 7'd127;
        retire(2'b11, 2'b11, 7'd7, 7'd9, 2'd2, "dual_wrap");
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd7 || bus.alloc_pr1 !== 7'd9) begin
            failed++;
            $display("FAIL dual_wrap_read: got %0d,%0d expected 7,9", bus.alloc_pr0, bus.alloc_pr1);
        end
        retire(2'b01, 2'b01, 7'd13, 7'd0, 2'd1, "after_wrap");
        bus.rd_ptr = 7'd1;
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd13 || bus.alloc_pr1 !== 7'd22) begin
            failed++;
            $display("FAIL after_wrap_read: got %0d,%0d expected 13,22", bus.alloc_pr0, bus.alloc_pr1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rd_ptr = 7'd64;
        for (int k = 0; k < 5; k++) begin
            retire(2'b11, 2'b11, 7'(1 + 2*k), 7'(2 + 2*k), 2'd2, "pre_reset");
        end
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd1 || bus.alloc_pr1 !== 7'd2) begin
            failed++;
            $display("FAIL pre_reset_read: got %0d,%0d expected 1,2", bus.alloc_pr0, bus.alloc_pr1);
        end
        bus.retire_valid   = 2'b11;
        bus.retire_wen     = 2'b11;
        bus.retire_old_pr0 = 7'd100;
        bus.retire_old_pr1 = 7'd101;
        bus.rd_ptr         = 7'd0;
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.PR_num_wrback !== 2'd0 || bus.alloc_pr0 !== 7'd32) begin
            failed++;
            $display("FAIL reset_mid: wrback=%0d alloc_pr0=%0d expected 0,32", bus.PR_num_wrback, bus.alloc_pr0);
        end
        bus.rd_ptr = 7'd73;
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd41 || bus.alloc_pr1 !== 7'd42) begin
            failed++;
            $display("FAIL reset_mid_entries: got %0d,%0d expected 41,42", bus.alloc_pr0, bus.alloc_pr1);
        end
        clear_retire();
        @(negedge clk);
        rst_n = 1'b1;
        model_wr = 7'b1000000;
        bus.rd_ptr = 7'd64;
        @(posedge clk);
        #1;
        retire(2'b01, 2'b01, 7'd50, 7'd0, 2'd1, "post_reset");
        #1;
        tests++;
        if (bus.alloc_pr0 !== 7'd50 || bus.alloc_pr1 !== 7'd33) begin
            failed++;
            $display("FAIL post_reset_ptr: got %0d,%0d expected 50,33", bus.alloc_pr0, bus.alloc_pr1);
        end
    endtask

`ifdef FREELIST_WB_REG_EN
    task automatic test_wb_reg();
        do_reset();
        bus.rd_ptr         = 7'd64;
        bus.retire_valid   = 2'b01;
        bus.retire_wen     = 2'b01;
        bus.retire_old_pr0 = 7'd3;
        @(negedge clk);
        tests++;
        if (bus.PR_num_wrback !== 2'd0 || bus.alloc_pr0 !== 7'd32) begin
            failed++;
            $display("FAIL wb_reg_t: wrback=%0d alloc=%0d expected 0,32", bus.PR_num_wrback, bus.alloc_pr0);
        end
        @(posedge clk);
        #1;
        clear_retire();
        @(negedge clk);
        tests++;
        if (bus.PR_num_wrback !== 2'd1 || bus.alloc_pr0 !== 7'd32) begin
            failed++;
            $display("FAIL wb_reg_t1: wrback=%0d alloc=%0d expected 1,32", bus.PR_num_wrback, bus.alloc_pr0);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.PR_num_wrback !== 2'd0 || bus.alloc_pr0 !== 7'd3) begin
            failed++;
            $display("FAIL wb_reg_t2: wrback=%0d alloc=%0d expected 0,3", bus.PR_num_wrback, bus.alloc_pr0);
        end
    endtask
`endif

    initial begin
        tests    = 0;
        failed   = 0;
        model_wr = 7'b1000000;
        rst_n    = 1'b0;
        clear_retire();
        bus.rd_ptr = '0;
        test_reset();
        test_single_slot1();
        test_no_free();
        test_dual_wrap();
        test_reset_mid();
`ifdef FREELIST_WB_REG_EN
        test_wb_reg();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
